// File: rtl/sp_pkg.sv
// Shared types and default constants for the SP frame reader.
// State codes, SPI command bytes and the power-up delay default.
package sp_pkg;

    typedef enum logic [2:0] {
        SP_S_IDLE    = 3'd0,
        SP_S_DELAY   = 3'd1,
        SP_S_RST     = 3'd2,
        SP_S_WAIT    = 3'd3,
        SP_S_CYCLE   = 3'd4,
        SP_S_UPDATE  = 3'd5,
        SP_S_READOUT = 3'd6,
        SP_S_FLUSH   = 3'd7
    } sp_state_e;

    localparam int         SP_DLY_CYC_DEF   = 40000;
    localparam logic [7:0] SP_CMD_IDLE_DEF  = 8'hE0;
    localparam logic [7:0] SP_CMD_CYCLE_DEF = 8'h00;

endpackage

// File: rtl/sp_frame_rd_if.sv
// Packed-word output stream of the SP frame reader.
// A word transfers on every clk edge where dout_valid and dout_ready are both high;
// once raised, dout_valid and dout/dout_last stay stable until that transfer.
interface sp_frame_rd_if #(
    parameter int W = 32
);
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;

    modport master (output dout, output dout_valid, output dout_last, input dout_ready);
    modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/sp_pack.sv
// Byte-to-word packer: fills lanes from bit 0 upward, flushes partial words
// zero-padded, and drops (flagging overflow) a word that finds the output occupied.
module sp_pack #(
    parameter int BYTES = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       byte_vld,
    input  logic [7:0] byte_in,
    input  logic       byte_eof,
    input  logic       flush,
    output logic       mid_word,
    output logic       overflow,
    sp_frame_rd_if.master out_if
);
    localparam int         W         = 8 * BYTES;
    localparam logic [3:0] LAST_LANE = 4'(BYTES - 1);

    logic [3:0]   lane;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_nxt;
    logic         word_done;
    logic         word_last;

    always_comb begin
        acc_nxt = acc_q;
        if (byte_vld) acc_nxt[8*int'(lane) +: 8] = byte_in;
        mid_word  = (lane != LAST_LANE);
        word_done = flush || (byte_vld && !mid_word);
        word_last = flush || (byte_vld && byte_eof);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lane              <= '0;
            acc_q             <= '0;
            overflow          <= 1'b0;
            out_if.dout       <= '0;
            out_if.dout_valid <= 1'b0;
            out_if.dout_last  <= 1'b0;
        end else if (word_done) begin
            // Clearing the accumulator here is what zero-fills lanes of a short word.
            lane  <= '0;
            acc_q <= '0;
            if (out_if.dout_valid && !out_if.dout_ready) begin
                overflow <= 1'b1;
            end else begin
                out_if.dout       <= acc_nxt;
                out_if.dout_valid <= 1'b1;
                out_if.dout_last  <= word_last;
            end
        end else begin
            if (byte_vld) begin
                lane  <= lane + 1'b1;
                acc_q <= acc_nxt;
            end
            if (out_if.dout_ready) out_if.dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sp_frame_rd.sv
// SP sensor frame reader: power-up sequencing, per-frame CYCLE commands and byte readout.
// Optional macro SP_RD_DEBUG_EN adds a debug input that substitutes a byte counter.
module sp_frame_rd
    import sp_pkg::*;
#(
    parameter int         BYTES     = 4,
    parameter int         DLY_CYC   = SP_DLY_CYC_DEF,
    parameter int         FCNT_W    = 16,
    parameter logic [7:0] CMD_IDLE  = SP_CMD_IDLE_DEF,
    parameter logic [7:0] CMD_CYCLE = SP_CMD_CYCLE_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              stop,
    input  logic [FCNT_W-1:0] n_frames,
    sp_frame_rd_if.master     out_if,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              overflow,
    output logic              spi_req,
    output logic [7:0]        spi_cmd,
    input  logic              spi_rdy,
    input  logic              spi_done,
    output logic              SP_CLK,
    output logic              SP_NRST,
    output logic [7:0]        SP_DIN,
    input  logic [7:0]        SP_DOUT,
    input  logic              SP_UPDATE,
    input  logic              SP_EOF,
`ifdef SP_RD_DEBUG_EN
    input  logic              debug,
`endif
    output logic [2:0]        state_dbg
);
    localparam logic [2:0] S_IDLE    = SP_S_IDLE;
    localparam logic [2:0] S_DELAY   = SP_S_DELAY;
    localparam logic [2:0] S_RST     = SP_S_RST;
    localparam logic [2:0] S_WAIT    = SP_S_WAIT;
    localparam logic [2:0] S_CYCLE   = SP_S_CYCLE;
    localparam logic [2:0] S_UPDATE  = SP_S_UPDATE;
    localparam logic [2:0] S_READOUT = SP_S_READOUT;
    localparam logic [2:0] S_FLUSH   = SP_S_FLUSH;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [31:0]       dly_cnt;
    logic              stop_seen;
    logic              byte_acc;
    logic              eof_acc;
    logic              mid_word;
    logic [7:0]        byte_in;
    logic [FCNT_W-1:0] cnt_inc;

    function automatic logic acq_end(input logic [FCNT_W-1:0] cnt, input logic stp,
                                     input logic [FCNT_W-1:0] nf);
        return stp || ((nf != '0) && (cnt >= nf));
    endfunction

    always_comb begin
        byte_acc  = (state == S_READOUT) && SP_UPDATE;
        eof_acc   = byte_acc && SP_EOF;
        cnt_inc   = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;
        state_nxt = state;
        case (state)
            S_IDLE:    if (spi_rdy) state_nxt = S_DELAY;
            S_DELAY:   if (dly_cnt == 32'(DLY_CYC - 1)) state_nxt = S_RST;
            S_RST:     if (spi_done) state_nxt = S_WAIT;
            S_WAIT:    if (start) state_nxt = S_CYCLE;
            S_CYCLE:   if (spi_done) state_nxt = S_UPDATE;
            S_UPDATE:  if (!SP_UPDATE) state_nxt = S_READOUT;
            S_READOUT: if (eof_acc) begin
                if (mid_word) state_nxt = S_FLUSH;
                else state_nxt = acq_end(cnt_inc, stop_seen || stop, n_frames) ? S_WAIT : S_CYCLE;
            end
            S_FLUSH:   state_nxt = acq_end(frame_cnt, stop_seen || stop, n_frames) ? S_WAIT : S_CYCLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            dly_cnt   <= '0;
            frame_cnt <= '0;
            stop_seen <= 1'b0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= (state == S_DELAY && state_nxt == S_DELAY) ? dly_cnt + 1'b1 : '0;
            if (state == S_WAIT && start) frame_cnt <= '0;
            else if (eof_acc) frame_cnt <= cnt_inc;
            // The stop request is scoped to the frame issued by the most recent CYCLE command.
            if (state == S_WAIT || (state != S_CYCLE && state_nxt == S_CYCLE)) stop_seen <= 1'b0;
            else if (stop) stop_seen <= 1'b1;
        end
    end

`ifdef SP_RD_DEBUG_EN
    logic [7:0] dbg_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) dbg_cnt <= '0;
        else if (byte_acc && debug) dbg_cnt <= dbg_cnt + 1'b1;
    end

    assign byte_in = debug ? dbg_cnt : SP_DOUT;
`else
    assign byte_in = SP_DOUT;
`endif

    sp_pack #(.BYTES(BYTES)) u_pack (
        .clk      (clk),
        .nrst     (nrst),
        .byte_vld (byte_acc),
        .byte_in  (byte_in),
        .byte_eof (SP_EOF),
        .flush    (state == S_FLUSH),
        .mid_word (mid_word),
        .overflow (overflow),
        .out_if   (out_if)
    );

    assign spi_req   = (state == S_RST || state == S_CYCLE) && spi_rdy;
    assign spi_cmd   = (state == S_RST) ? CMD_IDLE : (state == S_CYCLE) ? CMD_CYCLE : 8'h00;
    assign busy      = (state != S_WAIT);
    assign SP_CLK    = clk;
    assign SP_NRST   = (state != S_IDLE);
    assign SP_DIN    = 8'h00;
    assign state_dbg = state;

endmodule
